// File: rtl/banked_memory_pkg.sv
// banked_memory_pkg: shared op encodings and well-known address register indices
//   mem_op_e  : memory access requested on the bus
//   areg_op_e : update applied to the selected address register
package banked_memory_pkg;
   typedef enum logic [1:0] {MEM_NOP, MEM_READ, MEM_WRITE} mem_op_e;
   typedef enum logic [2:0] {
      AREG_NOP, AREG_INC, AREG_DEC, AREG_REL_ADD, AREG_REL_SUB, AREG_ABS_LO, AREG_ABS_HI
   } areg_op_e;
   localparam int AREG_PC  = 0;
   localparam int AREG_MAR = 1;
endpackage

// File: rtl/banked_memory_if.sv
// banked_memory_if: bus between the control unit (master) and banked_memory (slave)
//   in, word_sel, areg_sel, op, areg_op : master -> memory
//   out, out_valid, fault               : memory -> master
interface banked_memory_if import banked_memory_pkg::*; #(
   parameter int DATA_W    = 8,
   parameter int WORDS     = 2,
   parameter int NUM_AREGS = 3
);
   logic [DATA_W-1:0]            in;
   logic [DATA_W-1:0]            out;
   logic                         out_valid;
   logic                         fault;
   logic [$clog2(WORDS)-1:0]     word_sel;
   logic [$clog2(NUM_AREGS)-1:0] areg_sel;
   mem_op_e                      op;
   areg_op_e                     areg_op;
   modport master (output in, word_sel, areg_sel, op, areg_op, input out, out_valid, fault);
   modport slave  (input in, word_sel, areg_sel, op, areg_op, output out, out_valid, fault);
endinterface

// File: rtl/banked_memory_aregs.sv
// banked_memory_aregs: address register file with INC/DEC/relative/absolute updates
//   clock, reset : clock and async active-high reset (areg 0 -> PC_RESET, others -> 0)
//   in           : operand for relative/absolute updates
//   areg_sel     : register to read and update; values >= NUM_AREGS read 0 and do nothing
//   areg_op      : update to apply at the clock edge
//   addr         : pre-update value of the selected register
//   wrap         : carry/borrow strobe, only with BANKED_MEMORY_WRAP_FAULT_EN
module banked_memory_aregs import banked_memory_pkg::*; #(
   parameter int              DATA_W    = 8,
   parameter int              ADDR_W    = 9,
   parameter int              NUM_AREGS = 3,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [DATA_W-1:0]            in,
   input  logic [$clog2(NUM_AREGS)-1:0] areg_sel,
   input  areg_op_e                     areg_op,
   output logic [ADDR_W-1:0]            addr
`ifdef BANKED_MEMORY_WRAP_FAULT_EN
   ,
   output logic                         wrap
`endif
);
   localparam int SEL_W = $clog2(NUM_AREGS);
   logic [ADDR_W-1:0] areg [NUM_AREGS];
   logic [ADDR_W-1:0] opnd;
   logic [ADDR_W-1:0] nxt;
   logic              hit;
   logic              is_add;
   logic              is_sub;
   always_comb begin
      addr = '0;
      hit  = 1'b0;
      for (int i = 0; i < NUM_AREGS; i++) begin
         if (areg_sel == SEL_W'(i)) begin
            addr = areg[i];
            hit  = 1'b1;
         end
      end
   end
   assign is_add = areg_op == AREG_INC || areg_op == AREG_REL_ADD;
   assign is_sub = areg_op == AREG_DEC || areg_op == AREG_REL_SUB;
   assign opnd   = (areg_op == AREG_INC || areg_op == AREG_DEC) ? ADDR_W'(1) : ADDR_W'(in);
   assign nxt    = is_add                    ? addr + opnd :
                   is_sub                    ? addr - opnd :
                   areg_op == AREG_ABS_LO    ? ADDR_W'(in) :
                   areg_op == AREG_ABS_HI    ? {in[ADDR_W-DATA_W-1:0], addr[DATA_W-1:0]} :
                                               addr;
`ifdef BANKED_MEMORY_WRAP_FAULT_EN
   // a carry leaves the sum below the start value; a borrow means the operand exceeded it
   assign wrap = hit && (is_add ? nxt < addr : is_sub && opnd > addr);
`endif
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_AREGS; i++) areg[i] <= (i == AREG_PC) ? PC_RESET : '0;
      end else if (hit && areg_op != AREG_NOP) begin
         for (int i = 0; i < NUM_AREGS; i++) if (areg_sel == SEL_W'(i)) areg[i] <= nxt;
      end
   end
endmodule

// File: rtl/banked_memory.sv
// banked_memory: data store addressed by {areg[areg_sel], word_sel}, with registered read
//   clock : system clock, posedge only
//   reset : asynchronous, active-high
//   bus   : banked_memory_if slave (in, out, out_valid, word_sel, areg_sel, op, areg_op, fault)
// Optional macro BANKED_MEMORY_WRAP_FAULT_EN makes fault a sticky address-wrap flag;
// without it fault is tied to 0.
module banked_memory import banked_memory_pkg::*; #(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 9,
   parameter int                WORDS     = 2,
   parameter int                NUM_AREGS = 3,
   parameter logic [ADDR_W-1:0] PC_RESET  = '0
) (
   input logic             clock,
   input logic             reset,
   banked_memory_if.slave  bus
);
   localparam int WS_W  = $clog2(WORDS);
   localparam int DEPTH = (2 ** ADDR_W) * WORDS;
   logic [ADDR_W-1:0]      addr;
   logic [ADDR_W+WS_W-1:0] eff;
   logic [DATA_W-1:0]      cells [DEPTH];
`ifdef BANKED_MEMORY_WRAP_FAULT_EN
   logic wrap;
`endif
   banked_memory_aregs #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_AREGS(NUM_AREGS), .PC_RESET(PC_RESET)
   ) u_aregs (
      .clock(clock), .reset(reset), .in(bus.in), .areg_sel(bus.areg_sel),
      .areg_op(bus.areg_op), .addr(addr)
`ifdef BANKED_MEMORY_WRAP_FAULT_EN
      , .wrap(wrap)
`endif
   );
   assign eff = {addr, bus.word_sel};
   // the cell array has no reset, but a write must not land on an edge where reset is high
   always_ff @(posedge clock) begin
      if (!reset && bus.op == MEM_WRITE) cells[eff] <= bus.in;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.out       <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.op == MEM_READ;
         if (bus.op == MEM_READ) bus.out <= cells[eff];
      end
   end
`ifdef BANKED_MEMORY_WRAP_FAULT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) bus.fault <= 1'b0;
      else if (wrap) bus.fault <= 1'b1;
   end
`else
   assign bus.fault = 1'b0;
`endif
endmodule
